// File: rtl/alu_seq_param.sv
// alu_seq_param: multi-cycle ALU with add/sub, radix-4 Booth signed multiply and non-restoring unsigned divide
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BEGIN,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] operand_x,
    input  logic [WIDTH-1:0] operand_y,
    output logic             busy,
    output logic             END,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, ADDSUB, MUL_STEP, DIV_STEP, DIV_CORR, DONE} state_t;

    state_t           state;
    logic [1:0]       op;
    logic [WIDTH+1:0] a;
    logic [WIDTH-1:0] q, m;
    logic             qm1;
    logic [CNT_W-1:0] cnt;

    // M holds the multiplicand / left operand, or the divisor; Q holds the multiplier / right operand, or the dividend
    logic [WIDTH:0]   sum_as;
    logic [2:0]       dig;
    logic [WIDTH+1:0] m_ext, m_add, mul_sum;
    logic [WIDTH:0]   d_sh, d_m, d_new;
    logic [WIDTH-1:0] d_fix;

    assign sum_as  = {m[WIDTH-1], m} + (op[0] ? ~{q[WIDTH-1], q} : {q[WIDTH-1], q}) + {{WIDTH{1'b0}}, op[0]};
    assign dig     = {q[1:0], qm1};
    assign m_ext   = {{2{m[WIDTH-1]}}, m};
    assign m_add   = (dig == 3'b001 || dig == 3'b010) ? m_ext :
                     (dig == 3'b011) ? {m_ext[WIDTH:0], 1'b0} :
                     (dig == 3'b100) ? -{m_ext[WIDTH:0], 1'b0} :
                     (dig == 3'b101 || dig == 3'b110) ? -m_ext : '0;
    assign mul_sum = a + m_add;
    // Add/subtract decision uses the sign of A before the shift, the true sign of the partial remainder
    assign d_sh    = {a[WIDTH-1:0], q[WIDTH-1]};
    assign d_m     = {1'b0, m};
    assign d_new   = a[WIDTH] ? d_sh + d_m : d_sh - d_m;
    assign d_fix   = a[WIDTH] ? a[WIDTH-1:0] + m : a[WIDTH-1:0];

    // Operation sequencer: capture, iterate, publish results and pulse END
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op          <= '0;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            qm1         <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
            END         <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    END <= 1'b0;
                    if (BEGIN) begin
                        op       <= op_code;
                        m        <= (op_code == 2'b11) ? operand_y : operand_x;
                        q        <= (op_code == 2'b11) ? operand_x : operand_y;
                        qm1      <= 1'b0;
                        a        <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        if (op_code == 2'b11 && operand_y == '0) begin
                            result_lo   <= '1;
                            result_hi   <= operand_x;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            result_lo   <= '0;
                            result_hi   <= '0;
                            div_by_zero <= 1'b0;
                            state       <= op_code[1] ? (op_code[0] ? DIV_STEP : MUL_STEP) : ADDSUB;
                        end
                    end
                end
                ADDSUB: begin
                    result_lo <= sum_as[WIDTH-1:0];
                    result_hi <= {WIDTH{sum_as[WIDTH]}};
                    overflow  <= sum_as[WIDTH] ^ sum_as[WIDTH-1];
                    state     <= DONE;
                end
                MUL_STEP: begin
                    a   <= {{2{mul_sum[WIDTH+1]}}, mul_sum[WIDTH+1:2]};
                    q   <= {mul_sum[1:0], q[WIDTH-1:2]};
                    qm1 <= q[1];
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH/2 - 1)) state <= DONE;
                end
                DIV_STEP: begin
                    a   <= {d_new[WIDTH], d_new};
                    q   <= {q[WIDTH-2:0], ~d_new[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= DIV_CORR;
                end
                DIV_CORR: begin
                    result_lo <= q;
                    result_hi <= d_fix;
                    state     <= DONE;
                end
                DONE: begin
                    if (op == 2'b10) begin
                        result_hi <= a[WIDTH-1:0];
                        result_lo <= q;
                    end
                    END   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: directed and randomized checks of alu_seq_param at WIDTH=8 and WIDTH=16
module tb_alu_seq_param;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        b8 = 1'b0, b16 = 1'b0;
    logic [1:0]  op8 = '0, op16 = '0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic [15:0] x16 = '0, y16 = '0;
    logic        busy8, end8, ovf8, dbz8, busy16, end16, ovf16, dbz16;
    logic [7:0]  hi8, lo8;
    logic [15:0] hi16, lo16;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    alu_seq_param #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .BEGIN(b8), .op_code(op8), .operand_x(x8), .operand_y(y8),
        .busy(busy8), .END(end8), .result_hi(hi8), .result_lo(lo8), .overflow(ovf8), .div_by_zero(dbz8)
    );

    alu_seq_param #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .BEGIN(b16), .op_code(op16), .operand_x(x16), .operand_y(y16),
        .busy(busy16), .END(end16), .result_hi(hi16), .result_lo(lo16), .overflow(ovf16), .div_by_zero(dbz16)
    );

    // Reference results from plain integer arithmetic on the operand values
    function automatic void model(input int w, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] hi, output logic [15:0] lo, output logic o, output logic d,
                                  output int lat);
        longint one, mask, xu, yu, sx, sy, r;
        one  = 1;
        mask = (one << w) - 1;
        xu   = longint'(x) & mask;
        yu   = longint'(y) & mask;
        sx   = ((xu >> (w - 1)) != 0) ? xu - mask - 1 : xu;
        sy   = ((yu >> (w - 1)) != 0) ? yu - mask - 1 : yu;
        o    = 1'b0;
        d    = 1'b0;
        if (op[1] == 1'b0) begin
            r   = op[0] ? sx - sy : sx + sy;
            lo  = 16'(r & mask);
            hi  = (r < 0) ? 16'(mask) : 16'h0;
            o   = (r >= (one << (w - 1))) || (r < -(one << (w - 1)));
            lat = 2;
        end else if (op == 2'b10) begin
            r   = sx * sy;
            lo  = 16'(r & mask);
            hi  = 16'((r >>> w) & mask);
            lat = w / 2 + 1;
        end else if (yu == 0) begin
            lo  = 16'(mask);
            hi  = 16'(xu);
            d   = 1'b1;
            lat = 1;
        end else begin
            lo  = 16'(xu / yu);
            hi  = 16'(xu % yu);
            lat = w + 2;
        end
    endfunction

    task automatic drive(input int w, input logic b, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
        if (w == 8) begin
            b8 = b; op8 = op; x8 = x[7:0]; y8 = y[7:0];
        end else begin
            b16 = b; op16 = op; x16 = x; y16 = y;
        end
    endtask

    task automatic grab(input int w, output logic bz, output logic e, output logic o, output logic d,
                        output logic [15:0] hi, output logic [15:0] lo);
        if (w == 8) begin
            bz = busy8; e = end8; o = ovf8; d = dbz8; hi = {8'h00, hi8}; lo = {8'h00, lo8};
        end else begin
            bz = busy16; e = end16; o = ovf16; d = dbz16; hi = hi16; lo = lo16;
        end
    endtask

    // One transaction starting at a falling edge; jam keeps BEGIN high with junk operands while busy
    task automatic run_op(input int w, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y, input bit jam,
                          output logic [15:0] hi, output logic [15:0] lo, output logic o, output logic d,
                          output int lat);
        logic bz, e, o2, d2;
        logic [15:0] h2, l2;
        drive(w, 1'b1, op, x, y);
        @(negedge clk);
        drive(w, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
        grab(w, bz, e, o, d, hi, lo);
        tests++;
        if (bz !== 1'b1 || e !== 1'b0) begin
            fails++;
            $display("FAIL capture w=%0d busy=%b end=%b expected busy=1 end=0", w, bz, e);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            grab(w, bz, e, o, d, hi, lo);
            if (jam && e !== 1'b1) drive(w, 1'b1, 2'($urandom), 16'($urandom), 16'($urandom));
        end while (e !== 1'b1 && lat < 64);
        drive(w, 1'b0, op, x, y);
        tests++;
        if (e !== 1'b1 || bz !== 1'b0) begin
            fails++;
            $display("FAIL end_seen w=%0d op=%0d end=%b busy=%b expected end=1 busy=0 after %0d cycles", w, op, e, bz, lat);
        end
        @(negedge clk);
        grab(w, bz, e, o2, d2, h2, l2);
        tests++;
        if (e !== 1'b0 || bz !== 1'b0) begin
            fails++;
            $display("FAIL end_pulse w=%0d end=%b busy=%b expected 0/0 one cycle after END", w, e, bz);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy8, end8, hi8, lo8, ovf8, dbz8} !== 20'h0) begin
            fails++;
            $display("FAIL reset8 outputs=%h expected 0", {busy8, end8, hi8, lo8, ovf8, dbz8});
        end
        tests++;
        if ({busy16, end16, hi16, lo16, ovf16, dbz16} !== 36'h0) begin
            fails++;
            $display("FAIL reset16 outputs=%h expected 0", {busy16, end16, hi16, lo16, ovf16, dbz16});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  vop [11] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [7:0]  vx  [11] = '{8'h7F, 8'h05, 8'h80, 8'h80, 8'hFD, 8'h80, 8'h7F, 8'hC8, 8'h05, 8'hFF, 8'h2A};
        logic [7:0]  vy  [11] = '{8'h01, 8'h07, 8'h80, 8'h01, 8'h05, 8'h80, 8'h80, 8'h07, 8'h09, 8'h01, 8'h00};
        logic [7:0]  vhi [11] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h04, 8'h05, 8'h00, 8'h2A};
        logic [7:0]  vlo [11] = '{8'h80, 8'hFE, 8'h00, 8'h7F, 8'hF1, 8'h00, 8'h80, 8'h1C, 8'h00, 8'hFF, 8'hFF};
        logic        vo  [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        vd  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          vl  [11] = '{2, 2, 2, 2, 5, 5, 5, 10, 10, 10, 1};
        logic [15:0] hi, lo;
        logic        o, d;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            run_op(8, vop[i], {8'h00, vx[i]}, {8'h00, vy[i]}, 1'b0, hi, lo, o, d, lat);
            tests++;
            if (hi[7:0] !== vhi[i] || lo[7:0] !== vlo[i] || o !== vo[i] || d !== vd[i] || lat != vl[i]) begin
                fails++;
                $display("FAIL directed[%0d] op=%0d x=%h y=%h got hi=%h lo=%h ovf=%b dbz=%b lat=%0d expected hi=%h lo=%h ovf=%b dbz=%b lat=%0d",
                         i, vop[i], vx[i], vy[i], hi[7:0], lo[7:0], o, d, lat, vhi[i], vlo[i], vo[i], vd[i], vl[i]);
            end
        end
    endtask

    task automatic test_abort();
        int ends = 0;
        int busies = 0;
        drive(8, 1'b1, 2'b10, 16'h007F, 16'h0080);
        @(negedge clk);
        drive(8, 1'b0, 2'b10, 16'h007F, 16'h0080);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({busy8, end8, hi8, lo8, ovf8, dbz8} !== 20'h0) begin
            fails++;
            $display("FAIL abort_outputs outputs=%h expected 0", {busy8, end8, hi8, lo8, ovf8, dbz8});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ends += int'(end8);
            busies += int'(busy8);
        end
        tests++;
        if (ends != 0 || busies != 0) begin
            fails++;
            $display("FAIL abort_quiet end_count=%0d busy_count=%0d expected 0/0", ends, busies);
        end
    endtask

    task automatic test_busy_ignore();
        logic [1:0]  op;
        logic [15:0] x, y, hi, lo, ehi, elo;
        logic        o, d, eo, ed;
        int          lat, elat;
        for (int i = 0; i < 12; i++) begin
            op = 2'(i % 4);
            x  = {8'h00, 8'($urandom)};
            y  = {8'h00, 8'($urandom)};
            model(8, op, x, y, ehi, elo, eo, ed, elat);
            run_op(8, op, x, y, 1'b1, hi, lo, o, d, lat);
            tests++;
            if (hi !== ehi || lo !== elo || o !== eo || d !== ed || lat != elat) begin
                fails++;
                $display("FAIL busy_ignore op=%0d x=%h y=%h got %h_%h %b%b lat=%0d expected %h_%h %b%b lat=%0d",
                         op, x, y, hi, lo, o, d, lat, ehi, elo, eo, ed, elat);
            end
        end
    endtask

    task automatic test_random(input int w, input int n);
        logic [1:0]  op;
        logic [15:0] x, y, hi, lo, ehi, elo;
        logic        o, d, eo, ed;
        int          lat, elat;
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom);
            x  = 16'($urandom);
            y  = 16'($urandom);
            if (i % 97 == 0) begin
                op = 2'b10;
                x  = (w == 8) ? 16'h0080 : 16'h8000;
                y  = x;
            end else if (op == 2'b11 && i % 5 == 0) begin
                y = 16'($urandom_range(0, 3));
            end else if (op == 2'b11 && i % 5 == 1) begin
                y = x | 16'h0001;
                x = x >> 3;
            end
            model(w, op, x, y, ehi, elo, eo, ed, elat);
            run_op(w, op, x, y, (i % 13) == 0, hi, lo, o, d, lat);
            tests++;
            if (hi !== ehi || lo !== elo || o !== eo || d !== ed || lat != elat) begin
                fails++;
                $display("FAIL random w=%0d op=%0d x=%h y=%h got %h_%h %b%b lat=%0d expected %h_%h %b%b lat=%0d",
                         w, op, x & ((w == 8) ? 16'h00FF : 16'hFFFF), y & ((w == 8) ? 16'h00FF : 16'hFFFF),
                         hi, lo, o, d, lat, ehi, elo, eo, ed, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_busy_ignore();
        test_random(8, 400);
        test_random(16, 2500);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
